// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage:
//   - DEC_PC_W / OPC_W      : carried PC width and opcode field width
//   - OPCODE_*              : RV32 base opcode values recognised by decode
//   - dec_state_e           : occupancy state of the 2-entry skid buffer
//   - dec_entry_t           : one decoded entry {instr, pc, imm[, illegal]}
//   - DEC_ENTRY_W           : flattened width of dec_entry_t for port transport
//   - is_legal_opcode()     : opcode classification helper
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds the illegal bit to
// dec_entry_t. Without it no illegal bit is stored.
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int DEC_PC_W = 32;
    localparam int OPC_W    = 7;

    localparam logic [OPC_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPCODE_ALUI   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPCODE_ALU    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [DEC_PC_W-1:0] pc;
        logic [31:0]         imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic                illegal;
`endif
    } dec_entry_t;

    localparam int DEC_ENTRY_W = $bits(dec_entry_t);

    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
        logic legal;
        case (opc)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
            OPCODE_BRANCH, OPCODE_LOAD, OPCODE_STORE, OPCODE_ALUI,
            OPCODE_ALU, OPCODE_FENCE, OPCODE_SYSTEM: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// -----------------------------------------------------------------------------
// decode_skid_buf
// Two-entry FIFO (main = head, skid = tail) of dec_entry_t with an occupancy
// FSM. Flow-control flags are registered so nothing combinational reaches
// the upstream/downstream handshakes.
// Ports:
//   clk          in   clock
//   i_rst        in   synchronous active-high reset; empties and zeroes slots
//   i_flush      in   discard contents and any same-cycle push/pop
//   i_push       in   write i_push_entry (caller guarantees o_can_push)
//   i_push_entry in   entry to write, flattened dec_entry_t
//   i_pop        in   consume head entry (caller guarantees o_has_data)
//   o_head       out  head entry, flattened dec_entry_t
//   o_can_push   out  registered: buffer not full
//   o_has_data   out  registered: buffer not empty
// -----------------------------------------------------------------------------
module decode_skid_buf
    import decode_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DEC_ENTRY_W-1:0] i_push_entry,
    input  logic                   i_pop,
    output logic [DEC_ENTRY_W-1:0] o_head,
    output logic                   o_can_push,
    output logic                   o_has_data
);

    dec_state_e r_state;
    dec_state_e w_state_next;
    dec_entry_t r_main;
    dec_entry_t r_skid;
    dec_entry_t w_push_entry;
    logic       r_can_push;
    logic       r_has_data;
    logic       w_load_main_in;
    logic       w_load_main_skid;
    logic       w_load_skid;

    assign w_push_entry = i_push_entry;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            // Flush wins over any push/pop; slot contents are left stale.
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        w_state_next   = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (i_push && i_pop) begin
                        // Full-throughput case: head leaves, new entry takes its place.
                        w_load_main_in = 1'b1;
                    end else if (i_push) begin
                        w_state_next = TWO;
                        w_load_skid  = 1'b1;
                    end else if (i_pop) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (i_pop) begin
                        w_state_next     = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= EMPTY;
            r_can_push <= 1'b1;
            r_has_data <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_can_push <= (w_state_next != TWO);
            r_has_data <= (w_state_next != EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_push_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_push_entry;
            end
        end
    end

    assign o_head     = r_main;
    assign o_can_push = r_can_push;
    assign o_has_data = r_has_data;

endmodule

// File: rtl/decode_stage_ctrl.sv
// -----------------------------------------------------------------------------
// decode_stage_ctrl
// Decode-stage control: accepts fetched instructions (valid/ready), drives the
// external combinational ImmGen, captures {instr, pc, imm} together and
// presents them to execute through a 2-entry skid buffer (valid/ready).
// Flush discards everything; reset additionally zeroes the data outputs.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN
//   defined   : opcode classified at capture; unknown opcode stores illegal=1
//               and imm=0; out_illegal follows the head entry.
//   undefined : out_illegal tied to 0; imm stored exactly as returned.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      discard buffered and incoming instructions
//   in_valid/in_ready          fetch handshake (in_ready registered)
//   in_instr/in_pc             instruction word and its PC
//   immgen_instr/immgen_imm    ImmGen hookup (same-cycle)
//   out_valid/out_ready        execute handshake (out_valid registered)
//   out_instr/out_pc/out_imm   head entry fields
//   out_illegal                head entry opcode unrecognised
// Parameter PC_W may be at most DEC_PC_W (the width carried in dec_entry_t).
// -----------------------------------------------------------------------------
module decode_stage_ctrl
    import decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic [31:0]     immgen_instr,
    input  logic [31:0]     immgen_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_imm,
    output logic            out_illegal
);

    dec_entry_t             w_entry;
    dec_entry_t             w_head;
    logic [DEC_ENTRY_W-1:0] w_head_flat;
    logic                   w_can_push;
    logic                   w_has_data;
    logic                   w_push;
    logic                   w_pop;

    assign immgen_instr = in_instr;

    // Handshakes qualified with flush so a flushed cycle never moves data.
    assign w_push = in_valid && w_can_push && !flush;
    assign w_pop  = out_ready && w_has_data && !flush;

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic w_illegal;
    assign w_illegal = !is_legal_opcode(in_instr[OPC_W-1:0]);
`endif

    always_comb begin
        w_entry       = '0;
        w_entry.instr = in_instr;
        w_entry.pc    = DEC_PC_W'(in_pc);
        w_entry.imm   = immgen_imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
        w_entry.illegal = w_illegal;
        // ImmGen output is meaningless for unknown formats; keep it clean.
        if (w_illegal) begin
            w_entry.imm = '0;
        end
`endif
    end

    decode_skid_buf u_skid_buf (
        .clk          (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_push       (w_push),
        .i_push_entry (w_entry),
        .i_pop        (w_pop),
        .o_head       (w_head_flat),
        .o_can_push   (w_can_push),
        .o_has_data   (w_has_data)
    );

    assign w_head    = w_head_flat;
    assign in_ready  = w_can_push;
    assign out_valid = w_has_data;
    assign out_instr = w_head.instr;
    assign out_pc    = PC_W'(w_head.pc);
    assign out_imm   = w_head.imm;

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign out_illegal = w_head.illegal;
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_ctrl.sv
`timescale 1ns/1ps
module tb_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] immgen_instr;
    logic [31:0] immgen_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    // Stimulus table: instruction, PC, immediate the ImmGen returns, unknown opcode
    localparam logic [31:0] T_INSTR [8] = '{32'hFFF00093, 32'h0020A423, 32'h123450B7, 32'h00500113,
                                            32'h010000EF, 32'h00208463, 32'h0000007F, 32'h00000013};
    localparam logic [31:0] T_PC    [8] = '{32'h100, 32'h104, 32'h108, 32'h10C,
                                            32'h110, 32'h114, 32'h118, 32'h11C};
    localparam logic [31:0] T_IMM   [8] = '{32'hFFFFFFFF, 32'h00000008, 32'h12345000, 32'h00000005,
                                            32'h00000010, 32'h00000008, 32'hDEADBEEF, 32'h00000000};
    localparam bit          T_ILL   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    // Behavioural ImmGen (RV32 I/S/B/U/J formats); unknown opcodes return a marker.
    function automatic logic [31:0] model_imm(input logic [31:0] i);
        logic [31:0] r;
        case (i[6:0])
            7'h37, 7'h17: r = {i[31:12], 12'h000};
            7'h6F:        r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            7'h63:        r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h23:        r = {{21{i[31]}}, i[30:25], i[11:7]};
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: r = {{21{i[31]}}, i[30:20]};
            default:      r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    always_comb immgen_imm = model_imm(immgen_instr);

    function automatic exp_t mk_exp(input int k);
        exp_t e;
        e.instr = T_INSTR[k];
        e.pc    = T_PC[k];
        e.ill   = T_ILL[k] && ILL_EN;
        e.imm   = e.ill ? 32'h0 : T_IMM[k];
        return e;
    endfunction

    decode_stage_ctrl #(.PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .immgen_instr (immgen_instr),
        .immgen_imm   (immgen_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_illegal  (out_illegal)
    );

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_errors++; $display("FAIL reset_flags: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        n_checks++;
        if ({out_instr, out_pc, out_imm, out_illegal} !== 97'h0) begin
            n_errors++; $display("FAIL reset_data: instr=%h pc=%h imm=%h ill=%b, expected all zero",
                                 out_instr, out_pc, out_imm, out_illegal);
        end
        $display("reset done: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_single();
        exp_t e;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = T_INSTR[0]; in_pc = T_PC[0]; #1;
        if (in_valid && in_ready) sb.push_back(mk_exp(0));
        @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL single_latency: out_valid=%b, expected 1", out_valid);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++; $display("FAIL single_accept: in_ready=0 when empty, expected accept");
        end else begin
            e = sb.pop_front();
            if ({out_instr, out_pc, out_imm, out_illegal} !== {e.instr, e.pc, e.imm, e.ill}) begin
                n_errors++; $display("FAIL single_data: got instr=%h pc=%h imm=%h ill=%b, expected instr=%h pc=%h imm=%h ill=%b",
                                     out_instr, out_pc, out_imm, out_illegal, e.instr, e.pc, e.imm, e.ill);
            end else $display("pop instr=%h pc=%h imm=%h ill=%b", out_instr, out_pc, out_imm, out_illegal);
        end
        @(posedge clk); @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   idx = 1;
        int   cyc = 0;
        bit   started = 1'b0;
        out_ready = 1'b1;
        while ((idx <= 5 || sb.size() > 0) && cyc < 30) begin
            in_valid = (idx <= 5); in_instr = T_INSTR[idx % 8]; in_pc = T_PC[idx % 8]; #1;
            if (out_valid && out_ready) begin
                n_checks++; started = 1'b1;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL b2b_unexpected: instr=%h with nothing expected", out_instr);
                end else begin
                    e = sb.pop_front();
                    if ({out_instr, out_pc, out_imm, out_illegal} !== {e.instr, e.pc, e.imm, e.ill}) begin
                        n_errors++; $display("FAIL b2b_data: got instr=%h pc=%h imm=%h ill=%b, expected instr=%h pc=%h imm=%h ill=%b",
                                             out_instr, out_pc, out_imm, out_illegal, e.instr, e.pc, e.imm, e.ill);
                    end else $display("pop instr=%h pc=%h imm=%h ill=%b", out_instr, out_pc, out_imm, out_illegal);
                end
            end else if (started && sb.size() > 0) begin
                n_checks++; n_errors++;
                $display("FAIL b2b_bubble: out_valid=%b with %0d pending, expected 1", out_valid, sb.size());
            end
            if (in_valid && in_ready) begin sb.push_back(mk_exp(idx)); idx++; end
            @(posedge clk); @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || idx <= 5) begin
            n_errors++; $display("FAIL b2b_timeout: %0d pending, next idx %0d, expected all 5 through", sb.size(), idx);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   idx = 3;
        int   cyc = 0;
        while ((idx <= 5 || sb.size() > 0) && cyc < 30) begin
            out_ready = (cyc >= 4);
            in_valid = (idx <= 5); in_instr = T_INSTR[idx % 8]; in_pc = T_PC[idx % 8]; #1;
            if (cyc == 2 || cyc == 3) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++; $display("FAIL stall_in_ready: cycle %0d in_ready=%b, expected 0", cyc, in_ready);
                end
                n_checks++;
                if (sb.size() == 0 || out_valid !== 1'b1 || out_instr !== sb[0].instr) begin
                    n_errors++; $display("FAIL stall_hold: cycle %0d out_valid=%b instr=%h, expected 1 %h",
                                         cyc, out_valid, out_instr, T_INSTR[3]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL stall_unexpected: instr=%h with nothing expected", out_instr);
                end else begin
                    e = sb.pop_front();
                    if ({out_instr, out_pc, out_imm, out_illegal} !== {e.instr, e.pc, e.imm, e.ill}) begin
                        n_errors++; $display("FAIL stall_data: got instr=%h pc=%h imm=%h ill=%b, expected instr=%h pc=%h imm=%h ill=%b",
                                             out_instr, out_pc, out_imm, out_illegal, e.instr, e.pc, e.imm, e.ill);
                    end else $display("pop instr=%h pc=%h imm=%h ill=%b", out_instr, out_pc, out_imm, out_illegal);
                end
            end
            if (in_valid && in_ready) begin sb.push_back(mk_exp(idx)); idx++; end
            @(posedge clk); @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || idx <= 5) begin
            n_errors++; $display("FAIL stall_timeout: %0d pending, next idx %0d, expected all 3 through", sb.size(), idx);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        // Fill to TWO with execute stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = T_INSTR[k]; in_pc = T_PC[k];
            @(posedge clk); @(negedge clk);
        end
        in_instr = T_INSTR[2]; in_pc = T_PC[2]; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_errors++; $display("FAIL flush_two: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        $display("flush from TWO done");
        // Flush from ONE while a push and pop would otherwise both happen.
        in_valid = 1'b1; in_instr = T_INSTR[3]; in_pc = T_PC[3];
        @(posedge clk); @(negedge clk);
        in_instr = T_INSTR[4]; in_pc = T_PC[4]; flush = 1'b1;
        @(posedge clk); @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_errors++; $display("FAIL flush_one: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++; $display("FAIL flush_leak: out_valid=%b instr=%h, expected 0", out_valid, out_instr);
            end
        end
        // A fresh instruction after the flush must come straight through.
        in_valid = 1'b1; in_instr = T_INSTR[7]; in_pc = T_PC[7]; #1;
        if (in_ready) sb.push_back(mk_exp(7));
        @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
        n_checks++;
        if (sb.size() == 0 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL flush_resume: out_valid=%b in_ready-accepted=%0d, expected 1 1", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if ({out_instr, out_pc, out_imm, out_illegal} !== {e.instr, e.pc, e.imm, e.ill}) begin
                n_errors++; $display("FAIL flush_resume_data: got instr=%h pc=%h imm=%h, expected instr=%h pc=%h imm=%h",
                                     out_instr, out_pc, out_imm, e.instr, e.pc, e.imm);
            end else $display("pop instr=%h pc=%h imm=%h ill=%b", out_instr, out_pc, out_imm, out_illegal);
        end
        sb.delete();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = T_INSTR[2]; in_pc = T_PC[2];
        @(posedge clk); @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL rst_pending: out_valid=%b, expected 1", out_valid);
        end
        rst = 1'b1; in_instr = T_INSTR[3]; in_pc = T_PC[3];
        @(posedge clk); @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_errors++; $display("FAIL rst_flags: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        n_checks++;
        if ({out_instr, out_pc, out_imm, out_illegal} !== 97'h0) begin
            n_errors++; $display("FAIL rst_data: instr=%h pc=%h imm=%h ill=%b, expected all zero",
                                 out_instr, out_pc, out_imm, out_illegal);
        end
        @(posedge clk); @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_stay_empty: out_valid=%b, expected 0", out_valid);
        end
        $display("mid-transfer reset done");
    endtask

    task automatic test_illegal();
        exp_t e;
        int   idx = 6;
        int   cyc = 0;
        out_ready = 1'b1;
        while ((idx <= 7 || sb.size() > 0) && cyc < 20) begin
            in_valid = (idx <= 7); in_instr = T_INSTR[idx % 8]; in_pc = T_PC[idx % 8]; #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL illegal_unexpected: instr=%h with nothing expected", out_instr);
                end else begin
                    e = sb.pop_front();
                    if ({out_instr, out_pc, out_imm, out_illegal} !== {e.instr, e.pc, e.imm, e.ill}) begin
                        n_errors++; $display("FAIL illegal_data: got instr=%h pc=%h imm=%h ill=%b, expected instr=%h pc=%h imm=%h ill=%b",
                                             out_instr, out_pc, out_imm, out_illegal, e.instr, e.pc, e.imm, e.ill);
                    end else $display("pop instr=%h pc=%h imm=%h ill=%b", out_instr, out_pc, out_imm, out_illegal);
                end
            end
            if (in_valid && in_ready) begin sb.push_back(mk_exp(idx)); idx++; end
            @(posedge clk); @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || idx <= 7) begin
            n_errors++; $display("FAIL illegal_timeout: %0d pending, next idx %0d, expected both through", sb.size(), idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_rst_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
